// File: rtl/wb_bypass_sender_if.sv
// Write-back sender bus: per-pipe result inputs, the registered write-back
// pair, bypass-buffer backpressure and occupancy status.
interface wb_bypass_sender_if #(
  parameter int NUM_PIPE    = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int INDEX_W     = 5,
  parameter int DATA_W      = 32
);
  localparam int PEND_W = $clog2(NUM_PIPE*QUEUE_DEPTH+1);

  typedef struct packed {
    logic               v;
    logic [INDEX_W-1:0] idx;
  } dst_t;

  logic [NUM_PIPE-1:0]             I_Valid;
  dst_t [NUM_PIPE-1:0]             I_Index;
  logic [NUM_PIPE-1:0][DATA_W-1:0] I_Data;
  logic [NUM_PIPE-1:0]             O_Ready;
  logic                            I_Full;
  logic                            I_Stall;
  dst_t                            O_WB_Index;
  logic [DATA_W-1:0]               O_WB_Data;
  logic [PEND_W-1:0]               O_Pending;
  logic                            O_Empty;

  modport master (
    output I_Valid, I_Index, I_Data, I_Full, I_Stall,
    input  O_Ready, O_WB_Index, O_WB_Data, O_Pending, O_Empty
  );

  modport slave (
    input  I_Valid, I_Index, I_Data, I_Full, I_Stall,
    output O_Ready, O_WB_Index, O_WB_Data, O_Pending, O_Empty
  );
endinterface

// File: rtl/wb_bypass_sender.sv
// Write-back source: per-pipe result queues drained oldest-first, one
// (index, data) write-back per cycle into the register file / bypass buffer.
module wb_bypass_sender #(
  parameter int NUM_PIPE    = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int WIDTH_AGE   = $clog2(NUM_PIPE*QUEUE_DEPTH)+1,
  parameter int INDEX_W     = 5,
  parameter int DATA_W      = 32
) (
  input  logic               clock,
  input  logic               reset,
  wb_bypass_sender_if.slave  bus
);
  localparam int PW     = $clog2(QUEUE_DEPTH);
  localparam int PEND_W = $clog2(NUM_PIPE*QUEUE_DEPTH+1);
  localparam int SEL_W  = (NUM_PIPE > 1) ? $clog2(NUM_PIPE) : 1;

  logic [WIDTH_AGE-1:0] tag_mem  [NUM_PIPE][QUEUE_DEPTH];
  logic [INDEX_W-1:0]   idx_mem  [NUM_PIPE][QUEUE_DEPTH];
  logic [DATA_W-1:0]    data_mem [NUM_PIPE][QUEUE_DEPTH];
  logic [PW:0]          wr_ptr   [NUM_PIPE];
  logic [PW:0]          rd_ptr   [NUM_PIPE];

  logic [NUM_PIPE-1:0]  q_full, q_empty, push, pop;
  logic [WIDTH_AGE-1:0] age;
  logic [WIDTH_AGE-1:0] best_tag;
  logic                 found, issue;
  logic [SEL_W-1:0]     grant;
  logic [PEND_W-1:0]    n_push;

  logic                 wb_vld_p1;
  logic [INDEX_W-1:0]   wb_idx_p1;
  logic [DATA_W-1:0]    wb_data_p1;
  logic [PEND_W-1:0]    pending;

  function automatic logic [PEND_W-1:0] count_ones(input logic [NUM_PIPE-1:0] v);
    logic [PEND_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_PIPE; i++) n = n + PEND_W'(v[i]);
    return n;
  endfunction

  // Full/empty from registered pointers only; the extra MSB tells them apart.
  always_comb begin
    for (int p = 0; p < NUM_PIPE; p++) begin
      q_empty[p] = (wr_ptr[p] == rd_ptr[p]);
      q_full[p]  = (wr_ptr[p][PW] != rd_ptr[p][PW]) &&
                   (wr_ptr[p][PW-1:0] == rd_ptr[p][PW-1:0]);
      push[p]    = bus.I_Valid[p] & ~q_full[p];
    end
    n_push = count_ones(push);
  end

  // Oldest head wins; the strict modular compare leaves ties to the lower pipe.
  always_comb begin
    logic [WIDTH_AGE-1:0] head;
    logic [WIDTH_AGE-1:0] diff;
    found    = 1'b0;
    grant    = '0;
    best_tag = '0;
    head     = '0;
    diff     = '0;
    for (int p = 0; p < NUM_PIPE; p++) begin
      if (!q_empty[p]) begin
        head = tag_mem[p][rd_ptr[p][PW-1:0]];
        diff = head - best_tag;
        if (!found || diff[WIDTH_AGE-1]) begin
          found    = 1'b1;
          grant    = SEL_W'(p);
          best_tag = head;
        end
      end
    end
    issue = found & ~bus.I_Full & ~bus.I_Stall;
    pop   = '0;
    if (issue) pop[grant] = 1'b1;
  end

  // ---- stage p0: queue storage ----
  always_ff @(posedge clock) begin
    for (int p = 0; p < NUM_PIPE; p++) begin
      if (push[p]) begin
        tag_mem[p][wr_ptr[p][PW-1:0]]  <= age;
        idx_mem[p][wr_ptr[p][PW-1:0]]  <= bus.I_Index[p].idx;
        data_mem[p][wr_ptr[p][PW-1:0]] <= bus.I_Data[p];
      end
    end
  end

  // ---- stage p1: pointers, age, occupancy and the write-back register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < NUM_PIPE; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
      age        <= '0;
      wb_vld_p1  <= 1'b0;
      wb_idx_p1  <= '0;
      wb_data_p1 <= '0;
      pending    <= '0;
    end else begin
      for (int p = 0; p < NUM_PIPE; p++) begin
        wr_ptr[p] <= wr_ptr[p] + (PW+1)'(push[p]);
        rd_ptr[p] <= rd_ptr[p] + (PW+1)'(pop[p]);
      end
      if (|push) age <= age + 1'b1;
      wb_vld_p1 <= issue;
      if (issue) begin
        wb_idx_p1  <= idx_mem[grant][rd_ptr[grant][PW-1:0]];
        wb_data_p1 <= data_mem[grant][rd_ptr[grant][PW-1:0]];
      end
      pending <= pending + n_push - PEND_W'(issue);
    end
  end

  // A pipe presenting a result into a full queue loses it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PIPE; p++) begin
        assert (!(bus.I_Valid[p] && q_full[p]));
        assert (!bus.I_Valid[p] || bus.I_Index[p].v);
      end
    end
  end

  assign bus.O_Ready    = ~q_full;
  assign bus.O_WB_Index = {wb_vld_p1, wb_idx_p1};
  assign bus.O_WB_Data  = wb_data_p1;
  assign bus.O_Pending  = pending;
  assign bus.O_Empty    = (pending == '0) & ~wb_vld_p1;
endmodule

// File: tb/tb_wb_bypass_sender.sv
// Bench for wb_bypass_sender: directed and random traffic checked cycle by
// cycle against an arrival-ordered list model of all queued results.
module tb_wb_bypass_sender;
  localparam int NP = 2;
  localparam int QD = 4;
  localparam int IW = 5;
  localparam int DW = 8;

  typedef struct {
    int cyc;
    int pipe;
    int idx;
    int data;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  wb_bypass_sender_if #(.NUM_PIPE(NP), .QUEUE_DEPTH(QD), .INDEX_W(IW), .DATA_W(DW)) bif ();

  wb_bypass_sender #(.NUM_PIPE(NP), .QUEUE_DEPTH(QD), .INDEX_W(IW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif.slave)
  );

  always #5 clock = ~clock;

  ent_t mq[$];
  int   ecyc = 0;
  logic exp_v = 1'b0;
  int   exp_idx = 0;
  int   exp_data = 0;
  logic [NP-1:0] exp_ready = '1;
  int   n_total = 0;
  int   n_pass = 0;
  int   dut_wb = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic int cnt_of(input int p);
    int n = 0;
    for (int i = 0; i < mq.size(); i++) if (mq[i].pipe == p) n++;
    return n;
  endfunction

  // Reference: every queued result is one list entry; the write-back is the
  // earliest-arrived entry, lower pipe first among equal arrivals.
  task automatic model_edge();
    int cnt[NP];
    int best;
    if (reset) begin
      mq.delete();
      exp_v = 1'b0; exp_idx = 0; exp_data = 0;
    end else begin
      for (int p = 0; p < NP; p++) cnt[p] = cnt_of(p);
      best = -1;
      if (!bif.I_Full && !bif.I_Stall)
        for (int i = 0; i < mq.size(); i++)
          if (best < 0 || mq[i].cyc < mq[best].cyc ||
              (mq[i].cyc == mq[best].cyc && mq[i].pipe < mq[best].pipe)) best = i;
      if (best >= 0) begin
        exp_v = 1'b1; exp_idx = mq[best].idx; exp_data = mq[best].data;
        mq.delete(best);
      end else begin
        exp_v = 1'b0;
      end
      for (int p = 0; p < NP; p++)
        if (bif.I_Valid[p] && cnt[p] < QD)
          mq.push_back('{ecyc, p, int'(bif.I_Index[p].idx), int'(bif.I_Data[p])});
    end
    for (int p = 0; p < NP; p++) exp_ready[p] = (cnt_of(p) < QD);
    ecyc++;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("wb_v", 64'(bif.O_WB_Index.v), 64'(exp_v));
    if (exp_v) chk("wb_idx", 64'(bif.O_WB_Index.idx), 64'(exp_idx));
    chk("wb_data", 64'(bif.O_WB_Data), 64'(exp_data));
    chk("pending", 64'(bif.O_Pending), 64'(mq.size()));
    chk("ready", 64'(bif.O_Ready), 64'(exp_ready));
    chk("empty", 64'(bif.O_Empty), 64'(mq.size() == 0 && !exp_v));
    if (bif.O_WB_Index.v === 1'b1) dut_wb++;
  endtask

  task automatic drive(input int p, input int idx, input int data);
    bif.I_Valid[p]       = 1'b1;
    bif.I_Index[p].v     = 1'b1;
    bif.I_Index[p].idx   = IW'(idx);
    bif.I_Data[p]        = DW'(data);
  endtask

  task automatic idle();
    bif.I_Valid = '0;
    bif.I_Index = '0;
    bif.I_Data  = '0;
  endtask

  initial begin
    int sent[NP];
    int base;
    bit done;
    idle();
    bif.I_Full  = 1'b0;
    bif.I_Stall = 1'b0;

    // reset state
    reset = 1'b1;
    step(); step();
    chk("rst_ready", 64'(bif.O_Ready), 64'(2'b11));
    chk("rst_empty", 64'(bif.O_Empty), 64'd1);
    reset = 1'b0;

    // single result, 2-cycle latency
    drive(0, 5, 8'hA5);
    step();
    idle();
    step();
    chk("single_v", 64'(bif.O_WB_Index.v), 64'd1);
    chk("single_data", 64'(bif.O_WB_Data), 64'hA5);
    step();
    chk("single_empty", 64'(bif.O_Empty), 64'd1);

    // same-cycle collision: lower pipe first
    drive(0, 3, 8'h33); drive(1, 4, 8'h44);
    step();
    idle();
    step();
    chk("coll_first", 64'(bif.O_WB_Index.idx), 64'd3);
    step();
    chk("coll_second", 64'(bif.O_WB_Index.idx), 64'd4);
    step();

    // age ordering across a stall
    bif.I_Stall = 1'b1;
    drive(1, 7, 8'h01);
    step();
    idle(); drive(0, 7, 8'h02);
    step();
    idle();
    step();
    bif.I_Stall = 1'b0;
    step();
    chk("age_first", 64'(bif.O_WB_Data), 64'h01);
    step();
    chk("age_second", 64'(bif.O_WB_Data), 64'h02);
    step();

    // backpressure until pipe0's queue fills
    bif.I_Full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle();
      if (exp_ready[0]) drive(0, 10 + k, 8'h50 + k);
      step();
    end
    idle();
    chk("full_pending", 64'(bif.O_Pending), 64'd4);
    chk("full_ready0", 64'(bif.O_Ready[0]), 64'd0);
    bif.I_Full = 1'b0;
    for (int k = 0; k < 6; k++) step();

    // random streams with random Full, drained and counted
    sent = '{0, 0};
    base = dut_wb;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      idle();
      for (int p = 0; p < NP; p++)
        if (sent[p] < 20 && cnt_of(p) < QD && $urandom_range(0, 3) != 0) begin
          drive(p, int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
          sent[p]++;
        end
      bif.I_Full = ($urandom_range(0, 2) == 0);
      step();
      done = (sent[0] == 20 && sent[1] == 20 && mq.size() == 0 && !exp_v);
    end
    idle();
    bif.I_Full = 1'b0;
    chk("rand_done", 64'(done), 64'd1);
    chk("rand_count", 64'(dut_wb - base), 64'd40);

    // reset while entries are queued and an output is valid
    bif.I_Full = 1'b1;
    drive(0, 1, 8'h11); drive(1, 2, 8'h22);
    step();
    idle(); drive(0, 3, 8'h33);
    step();
    idle();
    bif.I_Full = 1'b0;
    step();
    chk("mid_v_before", 64'(bif.O_WB_Index.v), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_v", 64'(bif.O_WB_Index.v), 64'd0);
    chk("mid_pending", 64'(bif.O_Pending), 64'd0);
    chk("mid_ready", 64'(bif.O_Ready), 64'(2'b11));
    base = dut_wb;
    for (int k = 0; k < 4; k++) step();
    chk("mid_no_stale", 64'(dut_wb - base), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
